// File: rtl/if_stage_pkg.sv
// Shared fetch/pipeline definitions: the 32-bit word type, parameter defaults
// and the PC alignment helper.
package if_stage_pkg;

  typedef logic [31:0] word_t;

  localparam word_t DEF_RESET_PC  = 32'h0000_0000;
  localparam int    DEF_PC_STEP   = 4;
  localparam word_t DEF_NOP_INSTR = 32'h0000_0000;

  // Instructions are word-aligned, so a redirect target never carries low bits.
  function automatic word_t align_pc(input word_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register. The priority order is stall, then bubble, then load,
// which matches the downstream ID/EX and EX/MEM registers.
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter word_t NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic  Clk,
  input  logic  Rst_n,
  input  logic  stall,
  input  logic  bubble,
  input  word_t instr_in,
  input  word_t pc_inc_in,
  output word_t instr_out,
  output word_t pc_inc_out,
  output logic  valid_out
);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      instr_out  <= NOP_INSTR;
      pc_inc_out <= '0;
      valid_out  <= 1'b0;
    end else if (stall) begin
      instr_out  <= instr_out;
      pc_inc_out <= pc_inc_out;
      valid_out  <= valid_out;
    end else if (bubble) begin
      instr_out  <= NOP_INSTR;
      pc_inc_out <= '0;
      valid_out  <= 1'b0;
    end else begin
      instr_out  <= instr_in;
      pc_inc_out <= pc_inc_in;
      valid_out  <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register and sequencer, redirect handling with a
// pending slot for redirects that arrive during a stall, and the IF/ID register.
module if_stage
  import if_stage_pkg::*;
#(
  parameter word_t RESET_PC  = DEF_RESET_PC,
  parameter int    PC_STEP   = DEF_PC_STEP,
  parameter word_t NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic  Clk,
  input  logic  Rst_n,
  input  logic  stall,
  input  logic  bubble,
  input  logic  redirect,
  input  word_t redirect_target,
  output word_t imem_addr,
  input  word_t imem_data,
  output word_t pc_out,
  output word_t instr_out,
  output word_t pc_inc_out,
  output logic  valid_out
);

  localparam word_t STEP = word_t'(PC_STEP);

  word_t pc;
  word_t pc_next;
  word_t pc_inc;
  logic  pend_valid;
  word_t pend_target;
  logic  squash;

  assign imem_addr = pc;
  assign pc_out    = pc;
  assign pc_inc    = pc + STEP;

  // A fetched word is wrong-path if a redirect is taking effect this cycle,
  // whether fresh or released from the pending slot.
  assign squash = bubble | redirect | pend_valid;

  always_comb begin
    pc_next = pc_inc;
    if (stall)           pc_next = pc;
    else if (redirect)   pc_next = align_pc(redirect_target);
    else if (pend_valid) pc_next = align_pc(pend_target);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

  // Latest redirect seen during a stall wins; the slot is always emptied once
  // the stall releases, either consumed or superseded by a fresh redirect.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else if (stall) begin
      if (redirect) begin
        pend_valid  <= 1'b1;
        pend_target <= redirect_target;
      end
    end else begin
      pend_valid <= 1'b0;
    end
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .stall      (stall),
    .bubble     (squash),
    .instr_in   (imem_data),
    .pc_inc_in  (pc_inc),
    .instr_out  (instr_out),
    .pc_inc_out (pc_inc_out),
    .valid_out  (valid_out)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; instruction memory returns 32'h1000_0000 + addr.
module tb_if_stage;

  logic        Clk;
  logic        Rst_n;
  logic        stall;
  logic        bubble;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic [31:0] pc_inc_out;
  logic        valid_out;

  int errors = 0;
  int checks = 0;
  logic seen_100 = 1'b0;

  if_stage dut (
    .Clk             (Clk),
    .Rst_n           (Rst_n),
    .stall           (stall),
    .bubble          (bubble),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .pc_out          (pc_out),
    .instr_out       (instr_out),
    .pc_inc_out      (pc_inc_out),
    .valid_out       (valid_out)
  );

  assign imem_data = 32'h1000_0000 + imem_addr;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(negedge Clk) if (Rst_n && imem_addr == 32'h0000_0100) seen_100 = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                           input logic [31:0] inc, input logic vld);
    chk({tag, ".pc"},    pc_out,     pc);
    chk({tag, ".addr"},  imem_addr,  pc);
    chk({tag, ".instr"}, instr_out,  ins);
    chk({tag, ".inc"},   pc_inc_out, inc);
    chk({tag, ".valid"}, {31'b0, valid_out}, {31'b0, vld});
  endtask

  task automatic drive(input logic s, input logic b, input logic r, input logic [31:0] t);
    stall = s; bubble = b; redirect = r; redirect_target = t;
  endtask

  initial begin
    Rst_n = 1'b0;
    drive(0, 0, 0, 32'h0);
    #12;
    chk_state("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    Rst_n = 1'b1;

    // Sequential fetch
    step(); chk_state("seq1", 32'h4, 32'h1000_0000, 32'h4, 1'b1);
    step(); chk_state("seq2", 32'h8, 32'h1000_0004, 32'h8, 1'b1);

    // Redirect with misaligned target
    drive(0, 0, 1, 32'h0000_0043);
    step(); chk_state("redir", 32'h40, 32'h0, 32'h0, 1'b0);
    drive(0, 0, 0, 32'h0);
    step(); chk_state("redir_tgt", 32'h44, 32'h1000_0040, 32'h44, 1'b1);

    // Bring PC to 12
    drive(0, 0, 1, 32'h8);
    step(); chk_state("to8", 32'h8, 32'h0, 32'h0, 1'b0);
    drive(0, 0, 0, 32'h0);
    step(); chk_state("to12", 32'hC, 32'h1000_0008, 32'hC, 1'b1);

    // Three-cycle stall, redirect in the middle cycle
    drive(1, 0, 0, 32'h0);
    step(); chk_state("stall1", 32'hC, 32'h1000_0008, 32'hC, 1'b1);
    drive(1, 0, 1, 32'h80);
    step(); chk_state("stall2", 32'hC, 32'h1000_0008, 32'hC, 1'b1);
    drive(1, 0, 0, 32'h0);
    step(); chk_state("stall3", 32'hC, 32'h1000_0008, 32'hC, 1'b1);
    drive(0, 0, 0, 32'h0);
    step(); chk_state("pend_rel", 32'h80, 32'h0, 32'h0, 1'b0);
    step(); chk_state("pend_tgt", 32'h84, 32'h1000_0080, 32'h84, 1'b1);

    // Two redirects in one stall: latest wins
    drive(1, 0, 1, 32'h100);
    step(); chk_state("dbl1", 32'h84, 32'h1000_0080, 32'h84, 1'b1);
    drive(1, 0, 1, 32'h200);
    step(); chk_state("dbl2", 32'h84, 32'h1000_0080, 32'h84, 1'b1);
    drive(0, 0, 0, 32'h0);
    step(); chk_state("dbl_rel", 32'h200, 32'h0, 32'h0, 1'b0);
    step(); chk_state("dbl_tgt", 32'h204, 32'h1000_0200, 32'h204, 1'b1);
    chk("never_100", {31'b0, seen_100}, 32'h0);

    // Stall beats bubble; bubble alone flushes
    drive(1, 1, 0, 32'h0);
    step(); chk_state("stall_bub", 32'h204, 32'h1000_0200, 32'h204, 1'b1);
    drive(0, 1, 0, 32'h0);
    step(); chk_state("bubble", 32'h208, 32'h0, 32'h0, 1'b0);

    // PC wrap at the top of the address space
    drive(0, 0, 1, 32'hFFFF_FFFF);
    step(); chk_state("wrap_ld", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
    drive(0, 0, 0, 32'h0);
    step(); chk_state("wrap", 32'h0, 32'h0FFF_FFFC, 32'h0, 1'b1);
    step(); chk_state("post_wrap", 32'h4, 32'h1000_0000, 32'h4, 1'b1);

    // Async reset mid-stall with a pending redirect
    drive(1, 0, 1, 32'h300);
    step(); chk_state("pre_rst", 32'h4, 32'h1000_0000, 32'h4, 1'b1);
    drive(1, 0, 0, 32'h0);
    #2 Rst_n = 1'b0;
    #1 chk_state("async_rst", 32'h0, 32'h0, 32'h0, 1'b0);
    #3 Rst_n = 1'b1;
    drive(0, 0, 0, 32'h0);
    step(); chk_state("rst_rel", 32'h4, 32'h1000_0000, 32'h4, 1'b1);
    step(); chk_state("rst_rel2", 32'h8, 32'h1000_0004, 32'h8, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
